// File: rtl/ysyx_040066_pkg.sv
// Shared types for the memory arbiter: FSM encoding, line length and owner one-hot order.
package ysyx_040066_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_I    = 2'd1,
        ARB_DR   = 2'd2,
        ARB_DW   = 2'd3
    } arb_state_e;

    localparam logic [2:0] LINE_BEATS_M1 = 3'd7;

    localparam int OWN_I  = 0;
    localparam int OWN_DR = 1;
    localparam int OWN_DW = 2;

    typedef logic [2:0] owner_t;

    function automatic owner_t state_owner(input arb_state_e s);
        owner_t o;
        o = '0;
        case (s)
            ARB_I:   o[OWN_I]  = 1'b1;
            ARB_DR:  o[OWN_DR] = 1'b1;
            ARB_DW:  o[OWN_DW] = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ysyx_040066_rr_pick2.sv
// Two-way round-robin picker; on a tie the requester that did not win last time is chosen.
module ysyx_040066_rr_pick2 (
    input  logic clk,
    input  logic rst,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_take,
    output logic o_pick_a,
    output logic o_pick_b
);

    logic r_last_b;

    always_comb begin
        o_pick_a = i_req_a;
        o_pick_b = i_req_b;
        if (i_req_a && i_req_b) begin
            o_pick_a = r_last_b;
            o_pick_b = !r_last_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_b <= 1'b0;
        end else if (i_take && (o_pick_a || o_pick_b)) begin
            r_last_b <= o_pick_b;
        end
    end

endmodule

// File: rtl/ysyx_040066_mem_arbiter.sv
// Shares one memory port between icache fetch, dcache read and dcache write; grant is held to completion.
// Decision is registered in IDLE; steering, completion and the watchdog are combinational off the owner.
module ysyx_040066_mem_arbiter
    import ysyx_040066_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int ADDR_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ins_req,
    input  logic              i_ins_burst,
    input  logic [ADDR_W-1:0] i_ins_addr,
    output logic              o_ins_ready,
    output logic              o_ins_last,
    output logic              o_ins_err,
    output logic [63:0]       o_ins_data,
    input  logic              i_rd_req,
    input  logic [2:0]        i_rd_len,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_ready,
    output logic              o_rd_last,
    output logic              o_rd_err,
    output logic [63:0]       o_rd_data,
    input  logic              i_wr_req,
    input  logic [2:0]        i_wr_len,
    input  logic [7:0]        i_wr_mask,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [511:0]      i_wr_data,
    output logic              o_wr_ready,
    output logic              o_wr_err,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic              o_mem_burst,
    output logic [2:0]        o_mem_len,
    output logic [7:0]        o_mem_mask,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [511:0]      o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic              i_mem_last,
    input  logic              i_mem_err,
    input  logic [63:0]       i_mem_rdata
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_wdog;
    owner_t           w_own;
    logic             w_gnt;
    logic [2:0]       w_len;
    logic             w_beat;
    logic             w_cmp_ok;
    logic             w_cmp_err;
    logic             w_tmo;
    logic             w_end;
    logic             w_take;
    logic             w_pick_i;
    logic             w_pick_d;

    // Writes bypass the picker, so rr_last only moves on read grants.
    assign w_take = (r_state == ARB_IDLE) && !i_wr_req;

    ysyx_040066_rr_pick2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .i_req_a  (i_ins_req),
        .i_req_b  (i_rd_req),
        .i_take   (w_take),
        .o_pick_a (w_pick_i),
        .o_pick_b (w_pick_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog <= '0;
        end else if (!w_gnt || w_end) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + CNT_W'(1);
        end
    end

    always_comb begin
        w_own = state_owner(r_state);
        w_gnt = (r_state != ARB_IDLE);
        w_len = 3'd0;
        case (r_state)
            ARB_I:   w_len = i_ins_burst ? LINE_BEATS_M1 : 3'd0;
            ARB_DR:  w_len = i_rd_len;
            ARB_DW:  w_len = i_wr_len;
            default: w_len = 3'd0;
        endcase
        w_beat    = w_gnt && i_mem_ready && !i_mem_err;
        w_cmp_ok  = w_beat && (w_own[OWN_DW] || i_mem_last || (w_len == 3'd0));
        w_cmp_err = w_gnt && i_mem_err;
        // A real completion in the deadline cycle wins over the abort.
        w_tmo     = w_gnt && (TIMEOUT != 0) && !w_cmp_ok && !w_cmp_err
                    && (r_wdog == CNT_W'(TIMEOUT));
        w_end     = w_cmp_ok || w_cmp_err || w_tmo;

        w_state_nxt = r_state;
        if (r_state == ARB_IDLE) begin
            if (i_wr_req) begin
                w_state_nxt = ARB_DW;
            end else if (w_pick_i) begin
                w_state_nxt = ARB_I;
            end else if (w_pick_d) begin
                w_state_nxt = ARB_DR;
            end
        end else if (w_end) begin
            w_state_nxt = ARB_IDLE;
        end

        o_ins_ready = w_own[OWN_I] && (w_beat || w_tmo);
        o_ins_last  = w_own[OWN_I] && w_cmp_ok;
        o_ins_err   = w_own[OWN_I] && (w_cmp_err || w_tmo);
        o_ins_data  = w_own[OWN_I] ? i_mem_rdata : 64'd0;
        o_rd_ready  = w_own[OWN_DR] && (w_beat || w_tmo);
        o_rd_last   = w_own[OWN_DR] && w_cmp_ok;
        o_rd_err    = w_own[OWN_DR] && (w_cmp_err || w_tmo);
        o_rd_data   = w_own[OWN_DR] ? i_mem_rdata : 64'd0;
        o_wr_ready  = w_own[OWN_DW] && (w_cmp_ok || w_tmo);
        o_wr_err    = w_own[OWN_DW] && (w_cmp_err || w_tmo);

        o_mem_req   = w_gnt && !w_tmo;
        o_mem_we    = w_own[OWN_DW];
        o_mem_len   = w_len;
        o_mem_burst = (w_len != 3'd0);
        o_mem_mask  = w_own[OWN_DW] ? i_wr_mask : (w_gnt ? 8'hFF : 8'h00);
        o_mem_wdata = w_own[OWN_DW] ? i_wr_data : 512'd0;
        o_mem_addr  = '0;
        case (r_state)
            ARB_I:   o_mem_addr = i_ins_addr;
            ARB_DR:  o_mem_addr = i_rd_addr;
            ARB_DW:  o_mem_addr = i_wr_addr;
            default: o_mem_addr = '0;
        endcase
    end

endmodule

// File: tb/tb_ysyx_040066_mem_arbiter.sv
// Scenario bench for the memory arbiter: burst fetch, round-robin, write priority, error, watchdog, reset.
module tb_ysyx_040066_mem_arbiter;

    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst;
    logic ins_req, ins_burst;
    logic [63:0] ins_addr;
    logic ins_ready, ins_last, ins_err;
    logic [63:0] ins_data;
    logic rd_req;
    logic [2:0] rd_len;
    logic [63:0] rd_addr;
    logic rd_ready, rd_last, rd_err;
    logic [63:0] rd_data;
    logic wr_req;
    logic [2:0] wr_len;
    logic [7:0] wr_mask;
    logic [63:0] wr_addr;
    logic [511:0] wr_data;
    logic wr_ready, wr_err;
    logic mem_req, mem_we, mem_burst;
    logic [2:0] mem_len;
    logic [7:0] mem_mask;
    logic [63:0] mem_addr;
    logic [511:0] mem_wdata;
    logic mem_ready, mem_last, mem_err;
    logic [63:0] mem_rdata;

    int checks = 0;
    int failures = 0;
    int exp_own_q[$];
    logic [64:0] exp_beat_q[$];

    always #5 clk = ~clk;

    ysyx_040066_mem_arbiter #(.TIMEOUT(TMO), .ADDR_W(64)) dut (
        .clk(clk), .rst(rst),
        .i_ins_req(ins_req), .i_ins_burst(ins_burst), .i_ins_addr(ins_addr),
        .o_ins_ready(ins_ready), .o_ins_last(ins_last), .o_ins_err(ins_err), .o_ins_data(ins_data),
        .i_rd_req(rd_req), .i_rd_len(rd_len), .i_rd_addr(rd_addr),
        .o_rd_ready(rd_ready), .o_rd_last(rd_last), .o_rd_err(rd_err), .o_rd_data(rd_data),
        .i_wr_req(wr_req), .i_wr_len(wr_len), .i_wr_mask(wr_mask), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .o_wr_ready(wr_ready), .o_wr_err(wr_err),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_burst(mem_burst), .o_mem_len(mem_len),
        .o_mem_mask(mem_mask), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_ready(mem_ready), .i_mem_last(mem_last), .i_mem_err(mem_err), .i_mem_rdata(mem_rdata)
    );

    task automatic drive_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ins_req = 0; ins_burst = 0; ins_addr = '0;
        rd_req = 0; rd_len = '0; rd_addr = '0;
        wr_req = 0; wr_len = '0; wr_mask = '0; wr_addr = '0; wr_data = '0;
        mem_ready = 0; mem_last = 0; mem_err = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        ins_req = 1; wr_req = 1; mem_ready = 1; mem_err = 1; mem_rdata = 64'hDEAD_BEEF_0123_4567;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_burst, ins_ready, ins_last, ins_err, rd_ready, rd_last, rd_err, wr_ready, wr_err} !== 11'd0)
            begin failures++; $display("FAIL reset_ctrl: got %b want 0", {mem_req, ins_ready, ins_err, rd_ready, rd_err, wr_ready, wr_err}); end
        checks++;
        if ({mem_len, mem_mask, mem_addr, ins_data, rd_data} !== '0 || mem_wdata !== '0)
            begin failures++; $display("FAIL reset_data: addr %0h ins_data %0h want 0", mem_addr, ins_data); end
        drive_cycle();
        clear_inputs();
        rst = 0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin failures++; $display("FAIL idle_after_reset: mem_req %b want 0", mem_req); end
        drive_cycle();
    endtask

    task automatic test_ins_burst();
        int beats = 0;
        logic [63:0] d;
        logic [64:0] e;
        ins_req = 1; ins_burst = 1; ins_addr = 64'h8000_0040;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin failures++; $display("FAIL burst_registered: mem_req %b want 0", mem_req); end
        drive_cycle();
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_burst, mem_len, mem_mask} !== {1'b1, 1'b0, 1'b1, 3'd7, 8'hFF})
            begin failures++; $display("FAIL burst_fields: req %b we %b len %0d mask %h", mem_req, mem_we, mem_len, mem_mask); end
        checks++;
        if (mem_addr !== 64'h8000_0040) begin failures++; $display("FAIL burst_addr: got %h want 80000040", mem_addr); end
        for (int b = 0; b < 8; b++) begin
            drive_cycle();
            d = {$urandom, $urandom};
            mem_ready = 1; mem_rdata = d; mem_last = (b == 7);
            exp_beat_q.push_back({(b == 7), d});
            @(negedge clk);
            if (ins_ready) begin
                beats++;
                checks++;
                if (exp_beat_q.size() == 0) begin failures++; $display("FAIL burst_extra_beat: beat %0d", beats); end
                else begin
                    e = exp_beat_q.pop_front();
                    if ({ins_last, ins_data} !== e)
                        begin failures++; $display("FAIL burst_beat: got last %b data %h want last %b data %h", ins_last, ins_data, e[64], e[63:0]); end
                end
            end
            checks++;
            if ({rd_ready, rd_last, rd_err, wr_ready, ins_err} !== 5'd0)
                begin failures++; $display("FAIL burst_nonowner: got %b want 0", {rd_ready, rd_last, rd_err, wr_ready, ins_err}); end
        end
        drive_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (beats !== 8) begin failures++; $display("FAIL burst_beats: got %0d want 8", beats); end
        checks++;
        if (mem_req !== 1'b0) begin failures++; $display("FAIL burst_idle: mem_req %b want 0", mem_req); end
        exp_beat_q.delete();
        drive_cycle();
    endtask

    task automatic test_round_robin();
        int n_i = 0;
        int n_d = 0;
        int own, e;
        bit prev_done = 0;
        bit done_now;
        do_reset();
        for (int k = 0; k < 3; k++) begin exp_own_q.push_back(1); exp_own_q.push_back(0); end
        ins_req = 1; ins_burst = 0; ins_addr = 64'h1000;
        rd_req = 1; rd_len = 0; rd_addr = 64'h2000;
        for (int cyc = 0; cyc < 100 && (n_i < 3 || n_d < 3); cyc++) begin
            mem_ready = mem_req; mem_last = mem_req; mem_rdata = 64'(cyc);
            @(negedge clk);
            if (prev_done) begin
                checks++;
                if (mem_req !== 1'b0) begin failures++; $display("FAIL rr_idle_gap: mem_req %b want 0", mem_req); end
            end
            done_now = ins_ready || rd_ready;
            if (done_now) begin
                own = ins_ready ? 0 : 1;
                checks++;
                if (exp_own_q.size() == 0 || (ins_ready && rd_ready))
                    begin failures++; $display("FAIL rr_order: unexpected grant ins %b rd %b", ins_ready, rd_ready); end
                else begin
                    e = exp_own_q.pop_front();
                    if (own !== e) begin failures++; $display("FAIL rr_order: got owner %0d want %0d", own, e); end
                end
                if (own == 0) n_i++; else n_d++;
            end
            prev_done = done_now;
            drive_cycle();
            if (n_i == 3) ins_req = 0;
            if (n_d == 3) rd_req = 0;
        end
        checks++;
        if (n_i !== 3 || n_d !== 3) begin failures++; $display("FAIL rr_count: ins %0d rd %0d want 3 3", n_i, n_d); end
        exp_own_q.delete();
        clear_inputs();
        drive_cycle();
    endtask

    task automatic test_write_priority();
        logic [63:0] d;
        int e;
        exp_own_q.push_back(2);
        exp_own_q.push_back(1);
        for (int i = 0; i < 16; i++) wr_data[i*32 +: 32] = $urandom;
        wr_req = 1; wr_len = 7; wr_mask = 8'hFF; wr_addr = 64'h8000_1000;
        rd_req = 1; rd_len = 0; rd_addr = 64'h8000_1000;
        @(negedge clk);
        drive_cycle();
        mem_ready = 1;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_len, mem_mask, mem_addr} !== {1'b1, 1'b1, 3'd7, 8'hFF, 64'h8000_1000})
            begin failures++; $display("FAIL wr_fields: we %b len %0d mask %h addr %h", mem_we, mem_len, mem_mask, mem_addr); end
        checks++;
        if (mem_wdata !== wr_data) begin failures++; $display("FAIL wr_data: got %h want %h", mem_wdata[63:0], wr_data[63:0]); end
        checks++;
        e = exp_own_q.pop_front();
        if ({wr_ready, rd_ready} !== 2'b10 || e !== 2)
            begin failures++; $display("FAIL wr_first: wr_ready %b rd_ready %b want 1 0", wr_ready, rd_ready); end
        drive_cycle();
        wr_req = 0; mem_ready = 0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin failures++; $display("FAIL wr_idle_gap: mem_req %b want 0", mem_req); end
        drive_cycle();
        d = {$urandom, $urandom};
        mem_ready = 1; mem_last = 1; mem_rdata = d;
        @(negedge clk);
        checks++;
        e = exp_own_q.pop_front();
        if ({rd_ready, rd_last, mem_we, wr_ready} !== 4'b1100 || rd_data !== d || e !== 1)
            begin failures++; $display("FAIL rd_after_wr: ready %b last %b we %b data %h want 1 1 0 %h", rd_ready, rd_last, mem_we, rd_data, d); end
        drive_cycle();
        clear_inputs();
        drive_cycle();
    endtask

    task automatic test_read_err();
        rd_req = 1; rd_len = 0; rd_addr = 64'h4000;
        @(negedge clk);
        drive_cycle();
        mem_ready = 1; mem_err = 1;
        @(negedge clk);
        checks++;
        if ({rd_err, rd_ready, ins_err, mem_req} !== 4'b1001)
            begin failures++; $display("FAIL rd_err: err %b ready %b ins_err %b req %b want 1 0 0 1", rd_err, rd_ready, ins_err, mem_req); end
        drive_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({mem_req, rd_err} !== 2'b00) begin failures++; $display("FAIL rd_err_release: req %b err %b want 0 0", mem_req, rd_err); end
        drive_cycle();
    endtask

    task automatic test_timeout();
        int err_at = -1;
        ins_req = 1; ins_burst = 0; ins_addr = 64'h3000;
        @(negedge clk);
        drive_cycle();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ins_err) begin
                err_at = k;
                checks++;
                if ({ins_ready, mem_req} !== 2'b10)
                    begin failures++; $display("FAIL tmo_pulse: ready %b req %b want 1 0", ins_ready, mem_req); end
                break;
            end
            drive_cycle();
        end
        checks++;
        if (err_at !== TMO) begin failures++; $display("FAIL tmo_cycle: got %0d want %0d", err_at, TMO); end
        drive_cycle();
        ins_req = 0; mem_ready = 1; mem_last = 1;
        @(negedge clk);
        checks++;
        if ({ins_ready, ins_err, rd_ready, mem_req} !== 4'd0)
            begin failures++; $display("FAIL tmo_stray: got %b want 0", {ins_ready, ins_err, rd_ready, mem_req}); end
        drive_cycle();
        clear_inputs();
        drive_cycle();
    endtask

    task automatic test_rst_mid_burst();
        ins_req = 1; ins_burst = 1; ins_addr = 64'h8000_0100;
        @(negedge clk);
        drive_cycle();
        for (int b = 0; b < 2; b++) begin
            mem_ready = 1; mem_rdata = {$urandom, $urandom};
            @(negedge clk);
            drive_cycle();
        end
        mem_ready = 1; mem_rdata = 64'h1234_5678_9ABC_DEF0; rst = 1;
        #1;
        checks++;
        if ({mem_req, ins_ready, ins_last, ins_err, mem_burst, mem_len} !== 8'd0 || mem_addr !== '0 || ins_data !== '0)
            begin failures++; $display("FAIL rst_mid: req %b ready %b addr %h data %h want 0", mem_req, ins_ready, mem_addr, ins_data); end
        drive_cycle();
        rst = 0; mem_ready = 0; ins_burst = 0; ins_addr = 64'h8000_0200;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_idle: mem_req %b want 0", mem_req); end
        drive_cycle();
        @(negedge clk);
        checks++;
        if ({mem_req, mem_len} !== {1'b1, 3'd0} || mem_addr !== 64'h8000_0200)
            begin failures++; $display("FAIL rst_regrant: req %b len %0d addr %h", mem_req, mem_len, mem_addr); end
        drive_cycle();
        mem_ready = 1; mem_rdata = 64'hCAFE;
        @(negedge clk);
        checks++;
        if ({ins_ready, ins_last} !== 2'b11 || ins_data !== 64'hCAFE)
            begin failures++; $display("FAIL rst_complete: ready %b last %b data %h", ins_ready, ins_last, ins_data); end
        drive_cycle();
        clear_inputs();
        drive_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ins_burst();
        test_round_robin();
        test_write_priority();
        test_read_err();
        test_timeout();
        test_rst_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
